// File: rtl/echo_big_subwords_iter_if.sv
// Handshake/bus bundle for the iterative ECHO BIG.SubWords engine.
// The master drives jobs in and accepts results; the slave is the engine.
interface echo_big_subwords_iter_if #(
    parameter int unsigned CNT_W = 64
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2047:0]     state_in;
    logic [127:0]      salt;
    logic [CNT_W-1:0]  cnt_in;
    logic              out_valid;
    logic              out_ready;
    logic [2047:0]     state_out;
    logic [CNT_W-1:0]  cnt_out;

    modport master (
        output in_valid, state_in, salt, cnt_in, out_ready,
        input  in_ready, out_valid, state_out, cnt_out
    );

    modport slave (
        input  in_valid, state_in, salt, cnt_in, out_ready,
        output in_ready, out_valid, state_out, cnt_out
    );
endinterface

// File: rtl/echo_big_subwords_iter.sv
// Iterative ECHO BIG.SubWords: two AES rounds per 128-bit word (counter key, then salt),
// LANES round units time-shared over the 16 words of the 2048-bit state.
module echo_big_subwords_iter #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 64
) (
    input logic                     clk,
    input logic                     rst_n,
    echo_big_subwords_iter_if.slave bus
);
    localparam int unsigned NB    = 16 / LANES;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
        CNT_W < 1 || CNT_W > 64) begin : g_bad_param
        $error("echo_big_subwords_iter: LANES must divide 16 and CNT_W be 1..64");
    end

    typedef enum logic [1:0] {StIdle, StR1, StR2, StDone} state_e;

    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] p, r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = f_gmul(p, p);
            r = f_gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [127:0] f_round(input logic [127:0] w, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[4*c+r] = f_sbox(w[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c+1];
            a2 = s[4*c+2];
            a3 = s[4*c+3];
            o[127-32*c -: 32] = {f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3,
                                 f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3)};
        end
        return o ^ k;
    endfunction

    // Counter lands little-endian in bytes 0..7; bytes 8..15 are zero.
    function automatic logic [127:0] f_key1(input logic [CNT_W-1:0] base, input logic [3:0] w);
        logic [CNT_W-1:0] c;
        logic [63:0]      z, b;
        c = base + CNT_W'(w);
        z = 64'(c);
        for (int i = 0; i < 8; i++) b[63-8*i -: 8] = z[8*i +: 8];
        return {b, 64'h0};
    endfunction

    state_e            r_fsm;
    logic [IDX_W-1:0]  r_idx;
    logic [127:0]      r_words [16];
    logic [127:0]      r_salt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [2047:0]     r_state_out;
    logic [CNT_W-1:0]  r_cnt_out;

    logic [127:0]      w_next_words [16];
    logic [2047:0]     w_state_pack;

    always_comb begin : p_round
        logic [3:0]   wi;
        logic [127:0] key;
        wi           = '0;
        key          = '0;
        w_next_words = r_words;
        for (int l = 0; l < int'(LANES); l++) begin
            wi  = 4'(int'(r_idx) * int'(LANES) + l);
            key = (r_fsm == StR2) ? r_salt : f_key1(r_cnt, wi);
            w_next_words[wi] = f_round(r_words[wi], key);
        end
        w_state_pack = '0;
        for (int w = 0; w < 16; w++) w_state_pack[2047-128*w -: 128] = w_next_words[w];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= StIdle;
            r_idx       <= '0;
            for (int w = 0; w < 16; w++) r_words[w] <= '0;
            r_salt      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_state_out <= '0;
            r_cnt_out   <= '0;
        end else begin
            unique case (r_fsm)
                StIdle: begin
                    if (bus.in_valid) begin
                        for (int w = 0; w < 16; w++) r_words[w] <= bus.state_in[2047-128*w -: 128];
                        r_salt     <= bus.salt;
                        r_cnt      <= bus.cnt_in;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_fsm      <= StR1;
                    end
                end
                StR1, StR2: begin
                    r_words <= w_next_words;
                    if (r_idx == IDX_W'(NB - 1)) begin
                        r_idx <= '0;
                        if (r_fsm == StR1) begin
                            r_fsm <= StR2;
                        end else begin
                            r_fsm       <= StDone;
                            r_state_out <= w_state_pack;
                            r_cnt_out   <= r_cnt + CNT_W'(16);
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= StIdle;
                    end
                end
                default: r_fsm <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.state_out = r_state_out;
    assign bus.cnt_out   = r_cnt_out;
endmodule

// File: tb/tb_echo_big_subwords_iter.sv
// Bench for echo_big_subwords_iter: five LANES variants plus an 8-bit counter variant share
// stimulus; results are checked against a table-driven two-round AES model.
module tb_echo_big_subwords_iter;
    localparam int NI = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     in_valid, out_ready;
    logic [2047:0]            state_in;
    logic [127:0]             salt;
    logic [63:0]              cnt_in;
    logic [NI-1:0]            ov, ir;
    logic [NI-1:0][2047:0]    so;
    logic [NI-1:0][63:0]      co;

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L  = (g == 5) ? 4 : (1 << g);
        localparam int unsigned CW = (g == 5) ? 8 : 64;
        echo_big_subwords_iter_if #(.CNT_W(CW)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.state_in  = state_in;
        assign bus.salt      = salt;
        assign bus.cnt_in    = cnt_in[CW-1:0];
        assign bus.out_ready = out_ready;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign so[g] = bus.state_out;
        assign co[g] = 64'(bus.cnt_out);
        echo_big_subwords_iter #(.LANES(L), .CNT_W(CW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    logic [0:255][7:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic int lanes_of(input int i);
        return (i == 5) ? 4 : (1 << i);
    endfunction

    function automatic logic [63:0] mask_of(input int i);
        return (i == 5) ? 64'hFF : {64{1'b1}};
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input int k);
        logic [7:0] d;
        d = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        return (k == 1) ? a : (k == 2) ? d : (d ^ a);
    endfunction

    // Round on a 4x4 [row][col] byte matrix, straight from the AES definition.
    function automatic logic [127:0] m_round(input logic [127:0] w, input logic [127:0] key);
        logic [7:0]   st [4][4];
        logic [7:0]   sh [4][4];
        logic [7:0]   mc;
        logic [127:0] o;
        int           coef [4] = '{2, 3, 1, 1};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = sbox_tab[w[127-8*(4*c+r) -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) sh[r][c] = st[r][(c+r)%4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mc = 8'h00;
                for (int k = 0; k < 4; k++) mc = mc ^ m_mul(sh[k][c], coef[(k-r+4)%4]);
                o[127-8*(4*c+r) -: 8] = mc ^ key[127-8*(4*c+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [2047:0] model(input logic [2047:0] st, input logic [127:0] sl,
                                            input logic [63:0] cn, input logic [63:0] msk);
        logic [2047:0] res;
        logic [63:0]   ctr;
        logic [127:0]  k1;
        for (int w = 0; w < 16; w++) begin
            ctr = (cn + 64'(w)) & msk;
            k1  = '0;
            for (int i = 0; i < 8; i++) k1[127-8*i -: 8] = ctr[8*i +: 8];
            res[2047-128*w -: 128] = m_round(m_round(st[2047-128*w -: 128], k1), sl);
        end
        return res;
    endfunction

    function automatic logic [2047:0] rand_state();
        logic [2047:0] v;
        for (int k = 0; k < 64; k++) v[32*k +: 32] = $urandom();
        return v;
    endfunction

    task automatic run_job(input logic [2047:0] st, input logic [127:0] sl, input logic [63:0] cn);
        int            first [NI];
        logic [2047:0] exp_s;
        logic [63:0]   exp_c;
        int            bad_w;
        @(negedge clk);
        n_checks++;
        if (ir !== {NI{1'b1}}) $display("FAIL job_idle in_ready got %b want %b", ir, {NI{1'b1}});
        else n_pass++;
        state_in = st; salt = sl; cnt_in = cn; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        state_in = rand_state();
        salt     = {$urandom(), $urandom(), $urandom(), $urandom()};
        cnt_in   = {$urandom(), $urandom()};
        for (int i = 0; i < NI; i++) first[i] = -1;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) if (first[i] < 0 && ov[i] === 1'b1) first[i] = k;
        end
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (first[i] !== 32 / lanes_of(i))
                $display("FAIL latency inst%0d got %0d want %0d", i, first[i], 32 / lanes_of(i));
            else n_pass++;
            exp_s = model(st, sl, cn, mask_of(i));
            n_checks++;
            if (so[i] !== exp_s) begin
                bad_w = 0;
                for (int w = 15; w >= 0; w--)
                    if (so[i][2047-128*w -: 128] !== exp_s[2047-128*w -: 128]) bad_w = w;
                $display("FAIL state_out inst%0d word%0d got %h want %h", i, bad_w,
                         so[i][2047-128*bad_w -: 128], exp_s[2047-128*bad_w -: 128]);
            end else n_pass++;
            exp_c = (cn + 64'd16) & mask_of(i);
            n_checks++;
            if (co[i] !== exp_c) $display("FAIL cnt_out inst%0d got %h want %h", i, co[i], exp_c);
            else n_pass++;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_checks++;
        if (ov !== '0 || ir !== {NI{1'b1}})
            $display("FAIL release out_valid got %b want 0, in_ready got %b want all 1", ov, ir);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ir !== {NI{1'b1}}) $display("FAIL reset_in_ready got %b want all 1", ir); else n_pass++;
        n_checks++;
        if (ov !== '0) $display("FAIL reset_out_valid got %b want 0", ov); else n_pass++;
        n_checks++;
        if (so !== '0) $display("FAIL reset_state_out got nonzero want 0"); else n_pass++;
        n_checks++;
        if (co !== '0) $display("FAIL reset_cnt_out got nonzero want 0"); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (ov !== '0 || ir !== {NI{1'b1}})
                $display("FAIL idle_out_ready out_valid got %b in_ready got %b want 0 / all 1", ov, ir);
            else n_pass++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_zero();
        run_job('0, '0, '0);
        n_checks++;
        if (so[4][2047 -: 128] !== {16{8'hFB}})
            $display("FAIL zero_word0 got %h want %h", so[4][2047 -: 128], {16{8'hFB}});
        else n_pass++;
        n_checks++;
        if (co[4] !== 64'd16) $display("FAIL zero_cnt got %h want 10", co[4]); else n_pass++;
    endtask

    task automatic test_wrap();
        run_job(rand_state(), {$urandom(), $urandom(), $urandom(), $urandom()},
                64'hFFFF_FFFF_FFFF_FFF8);
        n_checks++;
        if (co[4] !== 64'h8) $display("FAIL wrap_cnt64 got %h want 8", co[4]); else n_pass++;
        n_checks++;
        if (co[5] !== 64'h8) $display("FAIL wrap_cnt8 got %h want 8", co[5]); else n_pass++;
    endtask

    task automatic test_hold();
        logic [2047:0] st, snap;
        logic [127:0]  sl;
        logic [63:0]   cn;
        st = rand_state();
        sl = {$urandom(), $urandom(), $urandom(), $urandom()};
        cn = {$urandom(), $urandom()};
        @(negedge clk);
        state_in = st; salt = sl; cnt_in = cn; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        for (int k = 0; k < 40 && ov !== {NI{1'b1}}; k++) @(negedge clk);
        n_checks++;
        if (ov !== {NI{1'b1}}) $display("FAIL hold_done out_valid got %b want all 1", ov);
        else n_pass++;
        snap = model(st, sl, cn, mask_of(4));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = k[0];
            state_in = rand_state();
            cnt_in   = {$urandom(), $urandom()};
            @(posedge clk); #1;
            n_checks++;
            if (so[4] !== snap || ov !== {NI{1'b1}})
                $display("FAIL hold_stable cycle%0d out_valid got %b want all 1, word0 got %h want %h",
                         k, ov, so[4][2047 -: 128], snap[2047 -: 128]);
            else n_pass++;
            n_checks++;
            if (ir !== '0) $display("FAIL hold_in_ready cycle%0d got %b want 0", k, ir);
            else n_pass++;
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_checks++;
        if (ov !== '0 || ir !== {NI{1'b1}})
            $display("FAIL hold_release out_valid got %b in_ready got %b want 0 / all 1", ov, ir);
        else n_pass++;
        run_job(rand_state(), {$urandom(), $urandom(), $urandom(), $urandom()},
                {$urandom(), $urandom()});
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        state_in = rand_state(); salt = {4{$urandom()}}; cnt_in = {$urandom(), $urandom()};
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        n_checks++;
        if (ov !== '0 || ir !== {NI{1'b1}})
            $display("FAIL abort out_valid got %b in_ready got %b want 0 / all 1", ov, ir);
        else n_pass++;
        n_checks++;
        if (so !== '0 || co !== '0) $display("FAIL abort_outputs got nonzero want 0"); else n_pass++;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        run_job(rand_state(), {$urandom(), $urandom(), $urandom(), $urandom()},
                {$urandom(), $urandom()});
    endtask

    task automatic test_random();
        for (int j = 0; j < 200; j++)
            run_job(rand_state(), {$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom()});
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; state_in = '0; salt = '0; cnt_in = '0;
        test_reset();
        test_zero();
        test_wrap();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog time limit reached, passed %0d of %0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
